// File: rtl/nibble_reg_pkg.sv
// -----------------------------------------------------------------------------
// nibble_reg_pkg
// Shared definitions for the nibble register arbiter:
//   NIBBLE_W     - width of one register lane (4 bits)
//   nibble_t     - one register lane
//   arb_state_e  - arbiter FSM states (ARB, HOLD)
//   wrap_inc     - increment with wrap at n-1 -> 0
// -----------------------------------------------------------------------------
package nibble_reg_pkg;

  localparam int NIBBLE_W = 4;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // (v + 1) mod n, without a divider.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/nibble_reg_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search: starting at index `start` and moving
// upward with wrap at N-1 -> 0, select the first set bit of `req`.
// Ports:
//   req   in  [N-1:0]          candidate vector
//   start in  [$clog2(N)-1:0]  first index examined
//   gnt   out [N-1:0]          one-hot grant, zero when req is zero
//   idx   out [$clog2(N)-1:0]  binary index of the grant (0 when none)
// -----------------------------------------------------------------------------
module rr_pick
  import nibble_reg_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IDX_W = $clog2(N);

  int unsigned cand;
  logic        found;

  // NOTE: every variable written here gets a value before any conditional
  // update, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 32'(start);
    for (int i = 0; i < N; i++) begin
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
      cand = wrap_inc(cand, N);
    end
  end

endmodule

// File: rtl/nibble_reg_arbiter.sv
// -----------------------------------------------------------------------------
// nibble_reg_arbiter
// Round-robin write arbiter owning a WIDTH x 4-bit state register. Each
// accepted beat writes the lanes selected by the winner's mask.
//
// Optional feature: define NIBREG_ARB_LOCK_EN to enable grant locking
// (req_lock holds the grant on the current owner until it sends a beat with
// lock low). Without it req_lock is unread and every beat re-arbitrates.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset
//   req_valid   in   [NREQ-1:0]                  requester presents a beat
//   req_ready   out  [NREQ-1:0]                  one-hot accept (0 in reset)
//   req_data    in   [NREQ-1:0][WIDTH-1:0][3:0]  write data per requester
//   req_mask    in   [NREQ-1:0][WIDTH-1:0]       lane write enables
//   req_lock    in   [NREQ-1:0]                  keep grant after this beat
//   out         out  [WIDTH-1:0][3:0]            register content
//   out_owner   out  [$clog2(NREQ)-1:0]          last accepted requester
//   out_update  out  pulse the cycle after out changed
// -----------------------------------------------------------------------------
module nibble_reg_arbiter
  import nibble_reg_pkg::*;
#(
  parameter int                                 WIDTH       = 8,
  parameter int                                 NREQ        = 4,
  parameter logic [WIDTH-1:0][NIBBLE_W-1:0]     RESET_VALUE = '1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NREQ-1:0]                       req_valid,
  output logic [NREQ-1:0]                       req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0][NIBBLE_W-1:0] req_data,
  input  logic [NREQ-1:0][WIDTH-1:0]            req_mask,
  input  logic [NREQ-1:0]                       req_lock,
  output logic [WIDTH-1:0][NIBBLE_W-1:0]        out,
  output logic [$clog2(NREQ)-1:0]               out_owner,
  output logic                                  out_update
);

  localparam int IDX_W = $clog2(NREQ);

  // Registered state
  nibble_t [WIDTH-1:0] out_q,    out_d;
  logic [IDX_W-1:0]    owner_q,  owner_d;
  logic [IDX_W-1:0]    ptr_q,    ptr_d;
  logic                update_q, update_d;

  // Arbitration
  logic [NREQ-1:0]     pick_gnt;
  logic [IDX_W-1:0]    pick_idx;
  logic [NREQ-1:0]     grant;
  logic [IDX_W-1:0]    win_idx;
  logic                xfer;
  nibble_t [WIDTH-1:0] win_data;
  logic [WIDTH-1:0]    win_mask;

  rr_pick #(.N(NREQ)) u_rr_pick (
    .req   (req_valid),
    .start (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx)
  );

`ifdef NIBREG_ARB_LOCK_EN
  arb_state_e state_q, state_d;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
`endif

  always_comb begin
    grant   = pick_gnt;
    win_idx = pick_idx;
`ifdef NIBREG_ARB_LOCK_EN
    // In HOLD the locked requester is the last accepted one, so owner_q
    // doubles as the hold index.
    if (state_q == HOLD) begin
      win_idx        = owner_q;
      grant          = '0;
      grant[owner_q] = req_valid[owner_q];
    end
`endif
    // No beat may complete on a reset edge.
    if (reset) grant = '0;
    xfer     = |grant;
    win_data = req_data[win_idx];
    win_mask = req_mask[win_idx];

    out_d    = out_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    update_d = 1'b0;
`ifdef NIBREG_ARB_LOCK_EN
    state_d  = state_q;
`endif
    if (xfer) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (win_mask[j]) out_d[j] = win_data[j];
      end
      owner_d  = win_idx;
      ptr_d    = IDX_W'(wrap_inc(32'(win_idx), NREQ));
      update_d = |win_mask;
`ifdef NIBREG_ARB_LOCK_EN
      // Same rule from either state: lock enters/stays in HOLD, unlock
      // returns to ARB.
      state_d  = req_lock[win_idx] ? HOLD : ARB;
`endif
    end
  end

  assign req_ready  = grant;
  assign out        = out_q;
  assign out_owner  = owner_q;
  assign out_update = update_q;

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register contents are architectural state seen by the
      // datapath, so unlike a plain storage array they are reset.
      out_q    <= RESET_VALUE;
      owner_q  <= '0;
      ptr_q    <= '0;
      update_q <= 1'b0;
`ifdef NIBREG_ARB_LOCK_EN
      state_q  <= ARB;
`endif
    end else begin
      out_q    <= out_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      update_q <= update_d;
`ifdef NIBREG_ARB_LOCK_EN
      state_q  <= state_d;
`endif
    end
  end

endmodule

// File: tb/tb_nibble_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nibble_reg_arbiter
// Directed self-checking bench for nibble_reg_arbiter (WIDTH=8, NREQ=4).
// Inputs change 1 time unit after the rising edge; outputs are compared
// in the same window (combinational ready) or after the next edge.
// -----------------------------------------------------------------------------
module tb_nibble_reg_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0][WIDTH-1:0][3:0] req_data;
  logic [NREQ-1:0][WIDTH-1:0]  req_mask;
  logic [NREQ-1:0]             req_lock;
  logic [WIDTH-1:0][3:0]       dut_out;
  logic [1:0]                  out_owner;
  logic                        out_update;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_reg_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_mask   (req_mask),
    .req_lock   (req_lock),
    .out        (dut_out),
    .out_owner  (out_owner),
    .out_update (out_update)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    req_valid = '0;
    req_lock  = '0;
    req_data  = '0;
    req_mask  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Moves the pointer to 3 with a zero-mask beat from requester 2.
  task automatic park_ptr_at_3();
    req_valid = 4'b0100;
    tick();
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    reset     = 1'b1;
    req_valid = '1;
    req_mask  = '1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready_pre: got %b want 0000", req_ready);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL reset_ready[%0d]: got %b want 0000", c, req_ready);
      end
      n_checks++;
      if (dut_out !== 32'hFFFFFFFF) begin
        n_fail++; $display("FAIL reset_out[%0d]: got %h want ffffffff", c, dut_out);
      end
      n_checks++;
      if (out_update !== 1'b0) begin
        n_fail++; $display("FAIL reset_update[%0d]: got %b want 0", c, out_update);
      end
      n_checks++;
      if (out_owner !== 2'd0) begin
        n_fail++; $display("FAIL reset_owner[%0d]: got %0d want 0", c, out_owner);
      end
    end
    drive_idle();
    reset = 1'b0;
    tick();
    n_checks++;
    if (dut_out !== 32'hFFFFFFFF || out_update !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: out %h upd %b want ffffffff 0", dut_out, out_update);
    end
  endtask

  task automatic test_masked_write();
    apply_reset();
    req_valid   = 4'b0100;
    req_data[2] = {8{4'h5}};
    req_mask[2] = 8'h0F;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL mw_ready: got %b want 0100", req_ready);
    end
    tick();
    drive_idle();
    n_checks++;
    if (dut_out !== 32'hFFFF5555) begin
      n_fail++; $display("FAIL mw_out: got %h want ffff5555", dut_out);
    end
    n_checks++;
    if (out_owner !== 2'd2) begin
      n_fail++; $display("FAIL mw_owner: got %0d want 2", out_owner);
    end
    n_checks++;
    if (out_update !== 1'b1) begin
      n_fail++; $display("FAIL mw_update: got %b want 1", out_update);
    end
    tick();
    n_checks++;
    if (out_update !== 1'b0 || dut_out !== 32'hFFFF5555) begin
      n_fail++; $display("FAIL mw_after: upd %b out %h want 0 ffff5555", out_update, dut_out);
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      req_data[i] = {8{4'(i + 1)}};
      req_mask[i] = 8'(1 << i);
    end
    for (int c = 0; c < 8; c++) begin
      logic [3:0] exp_ready;
      exp_ready = 4'(1 << (c % 4));
      #1;
      n_checks++;
      if (req_ready !== exp_ready || $countones(req_ready) != 1) begin
        n_fail++; $display("FAIL fair_ready[%0d]: got %b want %b", c, req_ready, exp_ready);
      end
      tick();
      n_checks++;
      if (out_owner !== 2'(c % 4) || out_update !== 1'b1) begin
        n_fail++; $display("FAIL fair_owner[%0d]: got %0d/%b want %0d/1", c, out_owner, out_update, c % 4);
      end
    end
    drive_idle();
    n_checks++;
    if (dut_out !== 32'hFFFF4321) begin
      n_fail++; $display("FAIL fair_out: got %h want ffff4321", dut_out);
    end
  endtask

  task automatic test_zero_mask();
    apply_reset();
    req_valid   = 4'b0010;
    req_data[1] = {8{4'h3}};
    req_mask[1] = 8'h00;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL zm_ready: got %b want 0010", req_ready);
    end
    tick();
    n_checks++;
    if (dut_out !== 32'hFFFFFFFF || out_update !== 1'b0 || out_owner !== 2'd1) begin
      n_fail++; $display("FAIL zm_state: out %h upd %b own %0d want ffffffff 0 1", dut_out, out_update, out_owner);
    end
    req_valid = 4'b1111;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL zm_next: got %b want 0100", req_ready);
    end
    drive_idle();
  endtask

  task automatic test_idle_keeps_ptr();
    apply_reset();
    park_ptr_at_3();
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL idle_ready: got %b want 0000", req_ready);
    end
    tick();
    tick();
    n_checks++;
    if (out_update !== 1'b0) begin
      n_fail++; $display("FAIL idle_update: got %b want 0", out_update);
    end
    req_valid = 4'b1111;
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL idle_ptr: got %b want 1000", req_ready);
    end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req_valid   = 4'b0001;
    req_data[0] = {8{4'h1}};
    req_mask[0] = 8'hFF;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL b2b_ready0: got %b want 0001", req_ready);
    end
    tick();
    n_checks++;
    if (dut_out !== 32'h11111111 || out_update !== 1'b1 || out_owner !== 2'd0) begin
      n_fail++; $display("FAIL b2b_beat0: out %h upd %b own %0d want 11111111 1 0", dut_out, out_update, out_owner);
    end
    drive_idle();
    req_valid   = 4'b0010;
    req_data[1] = {8{4'h2}};
    req_mask[1] = 8'hF0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL b2b_ready1: got %b want 0010", req_ready);
    end
    tick();
    drive_idle();
    n_checks++;
    if (dut_out !== 32'h22221111 || out_update !== 1'b1 || out_owner !== 2'd1) begin
      n_fail++; $display("FAIL b2b_beat1: out %h upd %b own %0d want 22221111 1 1", dut_out, out_update, out_owner);
    end
    tick();
    n_checks++;
    if (out_update !== 1'b0) begin
      n_fail++; $display("FAIL b2b_pulse_end: got %b want 0", out_update);
    end
  endtask

`ifdef NIBREG_ARB_LOCK_EN
  task automatic test_lock();
    apply_reset();
    park_ptr_at_3();
    req_valid = 4'b1111;
    for (int b = 0; b < 3; b++) begin
      req_lock[3] = (b < 2);
      #1;
      n_checks++;
      if (req_ready !== 4'b1000) begin
        n_fail++; $display("FAIL lock_beat[%0d]: got %b want 1000", b, req_ready);
      end
      tick();
    end
    req_lock = '0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL lock_release: got %b want 0001", req_ready);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_hold();
    apply_reset();
    park_ptr_at_3();
    req_valid   = 4'b1111;
    req_lock[3] = 1'b1;
    req_data[3] = {8{4'hA}};
    req_mask[3] = 8'hFF;
    tick();
    n_checks++;
    if (dut_out !== 32'hAAAAAAAA) begin
      n_fail++; $display("FAIL rmh_write: got %h want aaaaaaaa", dut_out);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL rmh_ready_in_reset: got %b want 0000", req_ready);
    end
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (dut_out !== 32'hFFFFFFFF || out_owner !== 2'd0) begin
      n_fail++; $display("FAIL rmh_state: out %h own %0d want ffffffff 0", dut_out, out_owner);
    end
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rmh_first_grant: got %b want 0001", req_ready);
    end
    drive_idle();
  endtask
`else
  task automatic test_lock_ignored();
    apply_reset();
    park_ptr_at_3();
    req_valid = 4'b1111;
    req_lock  = 4'b1111;
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL nolock_beat0: got %b want 1000", req_ready);
    end
    tick();
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL nolock_beat1: got %b want 0001", req_ready);
    end
    drive_idle();
  endtask
`endif

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_masked_write();
    test_fairness();
    test_zero_mask();
    test_idle_keeps_ptr();
    test_back_to_back();
`ifdef NIBREG_ARB_LOCK_EN
    test_lock();
    test_reset_mid_hold();
`else
    test_lock_ignored();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_reg_arbiter.md
# nibble_reg_arbiter

Round-robin write arbiter for the shared WIDTH×4-bit state register in the datapath.
- Shares the register between NREQ requesters; each requester writes whole beats under a per-nibble lane mask.
- The register itself lives inside this block, and its value is exported as `out`.
- Sits between the configuration/control masters and the datapath that consumes `out`.

## Interface
- `WIDTH`, 8, number of 4-bit lanes in the register.
- `NREQ`, 4, number of requesters; legal range 2..16.
- `RESET_VALUE`, -1 (all ones), reset content of the `[WIDTH-1:0][3:0]` register.
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  requester i presents a write beat.
- `req_ready`  out  NREQ  beat accepted this cycle; one-hot or zero.
- `req_data`  in  [NREQ-1:0][WIDTH-1:0][3:0]  write data per requester.
- `req_mask`  in  [NREQ-1:0][WIDTH-1:0]  per-lane write enable per requester.
- `req_lock`  in  NREQ  hold the grant after this beat; used only when `NIBREG_ARB_LOCK_EN` is defined.
- `out`  out  [WIDTH-1:0][3:0]  current register content.
- `out_owner`  out  $clog2(NREQ)  index of the last requester whose beat was accepted.
- `out_update`  out  1  one-cycle pulse the cycle after `out` changed.

## Operation
- Reset values:
  - `out` = RESET_VALUE; `out_owner` = 0; `out_update` = 0.
  - Round-robin pointer `ptr` = 0; FSM in ARB.
- FSM states:
  - ARB: winner is the first requester with `req_valid` set, searching from `ptr` upward with wrap at NREQ-1→0.
  - HOLD(k): only requester k may win; `req_ready` is 0 for all other requesters.
- Handshake:
  - `req_ready[w]` = `req_valid[w]` for the winner, combinational from registered state only.
  - A beat transfers when `req_valid & req_ready` are both 1.
  - Requesters must hold valid, data, mask and lock stable until ready.
- On transfer from winner w:
  - Each lane j with `req_mask[w][j]`=1 takes `req_data[w][j]`; other lanes keep their value.
  - `out_owner` ← w.
  - `ptr` ← (w+1) mod NREQ.
  - `out_update` ← 1 if the mask is non-zero, else 0.
- A transfer with an all-zero mask is legal: handshake completes, `out` is unchanged, no pulse, `ptr` still advances.
- No valid requesters: no ready, `ptr` is unchanged, `out_update` ← 0.
- Transitions (macro defined):
  - ARB→HOLD(w) on a transfer with `req_lock[w]`=1.
  - HOLD(k)→ARB on a transfer from k with `req_lock[k]`=0.
  - HOLD(k) persists while k is idle; no timeout, so the owner is responsible for releasing.
- Reset asserted in any state, including HOLD mid-burst: all state returns to reset values on that edge, and no transfer completes in that cycle (`req_ready` is forced 0 while `reset`=1).

## Timing
- Throughput: one beat per cycle, with back-to-back grants to different requesters allowed.
- Write latency: a transfer at edge N is visible on `out` after edge N; `out_update` is high during cycle N+1 only.
- Arbitration: zero cycles; `req_ready` is valid in the same cycle as `req_valid`.
- Fairness: with all NREQ requesters continuously valid and unlocked, grants rotate 0,1,…,NREQ-1,0.

## Configuration
- `NIBREG_ARB_LOCK_EN` defined:
  - HOLD state and `req_lock` are active.
  - A locked owner gets consecutive beats, blocking all other requesters.
- Not defined:
  - `req_lock` is ignored (port kept, unread).
  - The FSM is ARB only; every transfer re-arbitrates.

## Structure
- Shared package `nibble_reg_pkg` holds:
  - `NIBBLE_W`=4;
  - the lane typedef `nibble_t` (logic [3:0]);
  - the FSM enum `arb_state_e` {ARB, HOLD}.
- One sub-module, `rr_pick`: combinational priority search from a start pointer over an NREQ-bit vector. It returns a one-hot grant and a binary index.
- The register, pointer and FSM stay in the top.

## Test plan
- Reset: WIDTH=8, hold reset 2 cycles → `out`=32'hFFFFFFFF, `out_update`=0, `out_owner`=0, all `req_ready`=0 during reset.
- Masked write: requester 2 only, data all 4'h5, mask 8'h0F → after 1 edge `out`=32'hFFFF5555, `out_owner`=2, `out_update` pulses 1 cycle.
- Fairness: all four requesters valid for 8 cycles → ready sequence 0,1,2,3,0,1,2,3 with exactly one ready per cycle.
- Zero mask: requester 1, mask 0 → `req_ready[1]`=1, `out` unchanged, no pulse, next grant with all valid goes to requester 2.
- Lock (macro defined): requester 3 sends 3 beats with lock=1,1,0 while all others are valid → requester 3 wins 3 consecutive cycles, then requester 0.
- Reset mid-HOLD (macro defined): reset during HOLD(3) → next cycle ARB with `ptr`=0, `out`=RESET_VALUE, requester 0 granted first.
